// File: rtl/lotr_pkg.sv
// Shared types and constants for the lotr tile.
// Holds the C2F opcode type, UART command bytes and FSM state types.
package lotr_pkg;

  typedef enum logic [1:0] {
    RD = 2'b00,
    WR = 2'b01
  } t_opcode;

  localparam logic [7:0] UART_CMD_WR = 8'h57;
  localparam logic [7:0] UART_CMD_RD = 8'h52;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } t_bit_state;

  typedef enum logic [1:0] {
    CMD_OP,
    CMD_ADDR,
    CMD_DATA,
    CMD_ISSUE
  } t_cmd_state;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, bit FSM, baud counter.
// Ports: clk, rst, uart_rx in; byte_valid, byte_data, frame_err out.
module uart_rx_byte
  import lotr_pkg::*;
#(
  parameter int CPB       = 2083,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_C  = CW'(CPB);
  localparam logic [CW-1:0] HALF_C = CW'(CPB / 2);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [1:0]    sync;
  logic          rx;
  logic          rx_prev;
  t_bit_state    st;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          expire;

  assign rx     = sync[1];
  assign expire = (cnt == ONE_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync       <= 2'b11;
      rx_prev    <= 1'b1;
      st         <= BIT_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[0], uart_rx};
      rx_prev    <= rx;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (st)
        BIT_IDLE: begin
          if (rx_prev && !rx) begin
            cnt <= HALF_C;
            st  <= BIT_START;
          end
        end
        BIT_START: begin
          if (!expire) begin
            cnt <= cnt - ONE_C;
          end else if (rx) begin
            st <= BIT_IDLE;
          end else begin
            cnt     <= CPB_C;
            bit_idx <= '0;
            st      <= BIT_DATA;
          end
        end
        BIT_DATA: begin
          if (!expire) begin
            cnt <= cnt - ONE_C;
          end else begin
            if (LSB_FIRST) shift <= {rx, shift[7:1]};
            else           shift <= {shift[6:0], rx};
            cnt     <= CPB_C;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) st <= BIT_STOP;
          end
        end
        BIT_STOP: begin
          if (!expire) begin
            cnt <= cnt - ONE_C;
          end else begin
            // A low stop bit drops the byte; only one pulse fires.
            if (rx) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
            st <= BIT_IDLE;
          end
        end
        default: st <= BIT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART debug command engine: decodes W/R frames into C2F requests.
// Ports: clk, rst, uart_rx, req_stall in; C2F_Req*, error pulses out.
module uart_cmd_rx
  import lotr_pkg::*;
#(
  parameter int         CLK_FREQ_HZ = 20_000_000,
  parameter int         BAUD_RATE   = 9600,
  parameter bit         LSB_FIRST   = 1'b0,
  parameter int         N_DATA_BITS = 8,
  parameter logic [1:0] TID         = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        C2F_ReqValidQ500H,
  output t_opcode     C2F_ReqOpcodeQ500H,
  output logic [31:0] C2F_ReqAddressQ500H,
  output logic [31:0] C2F_ReqDataQ500H,
  output logic [1:0]  C2F_ReqThreadIDQ500H,
  input  logic        req_stall,
  output logic        frame_err,
  output logic        cmd_err,
  output logic        overrun
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;

  if (CPB < 4) begin : g_cpb_chk
    $error("uart_cmd_rx: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
  end
  if (N_DATA_BITS != 8) begin : g_nbits_chk
    $error("uart_cmd_rx: N_DATA_BITS must be 8");
  end

  logic       byte_valid;
  logic [7:0] byte_data;
  t_cmd_state st;
  logic [1:0] byte_cnt;

  uart_rx_byte #(
    .CPB       (CPB),
    .LSB_FIRST (LSB_FIRST)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign C2F_ReqThreadIDQ500H = TID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st                  <= CMD_OP;
      byte_cnt            <= '0;
      C2F_ReqValidQ500H   <= 1'b0;
      C2F_ReqOpcodeQ500H  <= RD;
      C2F_ReqAddressQ500H <= '0;
      C2F_ReqDataQ500H    <= '0;
      cmd_err             <= 1'b0;
      overrun             <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      overrun <= 1'b0;
      if (st == CMD_ISSUE) begin
        // Fields stay frozen until the fabric takes the request.
        if (!req_stall) begin
          C2F_ReqValidQ500H <= 1'b0;
          st                <= CMD_OP;
        end
        if (byte_valid) overrun <= 1'b1;
      end else if (frame_err) begin
        st <= CMD_OP;
      end else if (byte_valid) begin
        unique case (st)
          CMD_OP: begin
            byte_cnt <= '0;
            unique case (1'b1)
              (byte_data == UART_CMD_WR): begin
                C2F_ReqOpcodeQ500H <= WR;
                st                 <= CMD_ADDR;
              end
              (byte_data == UART_CMD_RD): begin
                C2F_ReqOpcodeQ500H <= RD;
                st                 <= CMD_ADDR;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
          CMD_ADDR: begin
            C2F_ReqAddressQ500H <= {C2F_ReqAddressQ500H[23:0], byte_data};
            byte_cnt            <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (C2F_ReqOpcodeQ500H == WR) begin
                st <= CMD_DATA;
              end else begin
                C2F_ReqDataQ500H  <= '0;
                C2F_ReqValidQ500H <= 1'b1;
                st                <= CMD_ISSUE;
              end
            end
          end
          CMD_DATA: begin
            C2F_ReqDataQ500H <= {C2F_ReqDataQ500H[23:0], byte_data};
            byte_cnt         <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              C2F_ReqValidQ500H <= 1'b1;
              st                <= CMD_ISSUE;
            end
          end
          default: st <= CMD_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed scoreboard bench for uart_cmd_rx.
// Drives UART frames, checks requests and error pulses.
module tb_uart_cmd_rx;
  import lotr_pkg::*;

  localparam int CLK_HZ = 160_000;
  localparam int BAUD   = 10_000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        req_stall;
  logic        valid;
  t_opcode     op;
  logic [31:0] addr;
  logic [31:0] data;
  logic [1:0]  tid;
  logic        frame_err;
  logic        cmd_err;
  logic        overrun;

  uart_cmd_rx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .LSB_FIRST   (1'b0),
    .N_DATA_BITS (8),
    .TID         (2'b00)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .uart_rx              (uart_rx),
    .C2F_ReqValidQ500H    (valid),
    .C2F_ReqOpcodeQ500H   (op),
    .C2F_ReqAddressQ500H  (addr),
    .C2F_ReqDataQ500H     (data),
    .C2F_ReqThreadIDQ500H (tid),
    .req_stall            (req_stall),
    .frame_err            (frame_err),
    .cmd_err              (cmd_err),
    .overrun              (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    t_opcode     op;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  req_t sb[$];
  int checks = 0;
  int errors = 0;
  int n_cmd_err = 0;
  int n_frame_err = 0;
  int n_overrun = 0;
  int n_accept = 0;
  int vlen = 0;
  int last_vlen = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      vlen = 0;
    end else begin
      if (cmd_err)   n_cmd_err++;
      if (frame_err) n_frame_err++;
      if (overrun)   n_overrun++;
      if (valid) begin
        vlen++;
        chk("req_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          chk("req_op",   64'(op),   64'(sb[0].op));
          chk("req_addr", 64'(addr), 64'(sb[0].addr));
          chk("req_data", 64'(data), 64'(sb[0].data));
          chk("req_tid",  64'(tid),  64'd0);
        end
        if (!req_stall) begin
          n_accept++;
          last_vlen = vlen;
          vlen = 0;
          if (sb.size() > 0) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 7; i >= 0; i--) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = stop_bit;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    if (!stop_bit) repeat (CPB) tick();
  endtask

  task automatic push_req(input t_opcode o, input logic [31:0] a,
                          input logic [31:0] d);
    req_t r;
    r.op = o;
    r.addr = a;
    r.data = d;
    sb.push_back(r);
  endtask

  task automatic send_words(input logic [31:0] a, input logic [31:0] d,
                            input int nbytes);
    logic [63:0] w;
    w = {a, d};
    for (int i = 0; i < nbytes; i++) begin
      send_byte(w[63-8*i -: 8], 1'b1);
    end
  endtask

  task automatic send_w(input logic [31:0] a, input logic [31:0] d);
    send_byte(UART_CMD_WR, 1'b1);
    send_words(a, d, 8);
  endtask

  task automatic send_r(input logic [31:0] a);
    send_byte(UART_CMD_RD, 1'b1);
    send_words(a, 32'h0, 4);
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    req_stall = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_op", 64'(op), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data", 64'(data), 64'd0);
    chk("rst_tid", 64'(tid), 64'd0);
    chk("rst_ferr", 64'(frame_err), 64'd0);
    chk("rst_cerr", 64'(cmd_err), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    rst = 1'b0;
    repeat (CPB) tick();

    push_req(WR, 32'h1234_5678, 32'hDEAD_BEEF);
    send_w(32'h1234_5678, 32'hDEAD_BEEF);
    repeat (2 * CPB) tick();
    chk("wr_accept", 64'(n_accept), 64'd1);
    chk("wr_vlen", 64'(last_vlen), 64'd1);

    push_req(RD, 32'h0000_1000, 32'h0);
    send_r(32'h0000_1000);
    repeat (2 * CPB) tick();
    chk("rd_accept", 64'(n_accept), 64'd2);
    chk("rd_vlen", 64'(last_vlen), 64'd1);

    send_byte(8'h41, 1'b1);
    repeat (CPB) tick();
    chk("bad_cmd_err", 64'(n_cmd_err), 64'd1);
    push_req(WR, 32'hCAFE_F00D, 32'h0102_0304);
    send_w(32'hCAFE_F00D, 32'h0102_0304);
    repeat (2 * CPB) tick();
    chk("bad_then_wr", 64'(n_accept), 64'd3);
    chk("bad_cmd_once", 64'(n_cmd_err), 64'd1);

    send_byte(UART_CMD_RD, 1'b1);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b0);
    repeat (CPB) tick();
    chk("ferr_pulse", 64'(n_frame_err), 64'd1);
    chk("ferr_noreq", 64'(n_accept), 64'd3);
    push_req(RD, 32'h0000_2000, 32'h0);
    send_r(32'h0000_2000);
    repeat (2 * CPB) tick();
    chk("ferr_then_rd", 64'(n_accept), 64'd4);

    req_stall = 1'b1;
    push_req(WR, 32'h8000_0004, 32'h5A5A_A5A5);
    send_byte(UART_CMD_WR, 1'b1);
    send_words(32'h8000_0004, 32'h5A5A_A5A5, 7);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        int t;
        t = 0;
        while (!valid && t < 20 * CPB) begin
          tick();
          t++;
        end
        chk("stall_valid_seen", 64'(valid), 64'd1);
        repeat (7) tick();
        req_stall = 1'b0;
      end
    join
    repeat (2 * CPB) tick();
    chk("stall_accept", 64'(n_accept), 64'd5);
    chk("stall_vlen", 64'(last_vlen), 64'd8);

    req_stall = 1'b1;
    push_req(WR, 32'h0000_00FF, 32'hFFFF_0000);
    send_w(32'h0000_00FF, 32'hFFFF_0000);
    send_byte(8'h52, 1'b1);
    repeat (CPB) tick();
    chk("ovr_pulse", 64'(n_overrun), 64'd1);
    chk("ovr_held", 64'(valid), 64'd1);
    chk("ovr_noacc", 64'(n_accept), 64'd5);
    req_stall = 1'b0;
    repeat (2 * CPB) tick();
    chk("ovr_accept", 64'(n_accept), 64'd6);

    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (4 * CPB) tick();
    chk("glitch_nocmd", 64'(n_cmd_err), 64'd1);
    chk("glitch_noferr", 64'(n_frame_err), 64'd1);
    chk("glitch_noreq", 64'(n_accept), 64'd6);

    send_byte(UART_CMD_WR, 1'b1);
    send_byte(8'h12, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) tick();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) tick();
    chk("rst_mid_valid", 64'(valid), 64'd0);
    rst = 1'b0;
    repeat (CPB) tick();
    push_req(RD, 32'hFEDC_BA98, 32'h0);
    send_r(32'hFEDC_BA98);
    repeat (2 * CPB) tick();
    chk("rst_then_rd", 64'(n_accept), 64'd7);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_ovr", 64'(n_overrun), 64'd1);
    chk("final_ferr", 64'(n_frame_err), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
